// File: rtl/axis_sync_packet_fifo_if.sv
// AXI-Stream bundle for axis_sync_packet_fifo: data, byte enables, frame end and bad-frame flag.
// tuser is only meaningful towards the FIFO; the FIFO drives it low on its output side.
interface axis_sync_packet_fifo_if #(
  parameter int DATA_WIDTH = 64
);
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tkeep;
  logic                    tlast;
  logic                    tuser;
  logic                    tvalid;
  logic                    tready;

  modport master (output tdata, tkeep, tlast, tuser, tvalid, input tready);
  modport slave  (input tdata, tkeep, tlast, tuser, tvalid, output tready);
endinterface

// File: rtl/axis_sync_packet_fifo.sv
// Single-clock AXI-Stream FIFO with registered FWFT output, fill level and optional
// store-and-forward packet mode that drops bad or oversize frames.
//
// state   | meaning
// WR_IDLE | between frames; next accepted beat starts a frame
// WR_PKT  | inside a frame, beats written but not yet visible to the reader
// WR_DROP | frame outgrew the memory; swallow beats until tlast
module axis_sync_packet_fifo #(
  parameter int DATA_WIDTH   = 64,
  parameter int ADDR_WIDTH   = 9,
  parameter bit PACKET_MODE  = 1'b1,
  parameter int ALMOST_FULL  = 4,
  parameter int ALMOST_EMPTY = 2
) (
  input  logic                           clk_i,
  input  logic                           s_rst_i,
  axis_sync_packet_fifo_if.slave         s_axis,
  axis_sync_packet_fifo_if.master        m_axis,
  output logic [ADDR_WIDTH:0]            level_o,
  output logic                           almost_full_o,
  output logic                           almost_empty_o,
  output logic                           drop_o,
  output logic                           good_frame_o
);
  localparam int KEEP_W  = DATA_WIDTH / 8;
  localparam int MEM_W   = DATA_WIDTH + KEEP_W + 1;
  localparam int DEPTH_N = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0] AF_TH = ALMOST_FULL[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AE_TH = ALMOST_EMPTY[ADDR_WIDTH:0];

  localparam logic [1:0] WR_IDLE = 2'd0;
  localparam logic [1:0] WR_PKT  = 2'd1;
  localparam logic [1:0] WR_DROP = 2'd2;

  logic [MEM_W-1:0]    mem [DEPTH_N];
  logic [ADDR_WIDTH:0] wr_ptr_cur;
  logic [ADDR_WIDTH:0] wr_ptr_commit;
  logic [ADDR_WIDTH:0] rd_ptr;
  logic [ADDR_WIDTH:0] frame_len_next;
  logic [1:0]          wr_state;
  logic                full;
  logic                in_drop;
  logic                wr_en;
  logic                rd_load;

  assign full = (wr_ptr_cur[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                (wr_ptr_cur[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
  assign in_drop        = (wr_state == WR_DROP);
  assign s_axis.tready  = !s_rst_i && (!full || in_drop);
  assign wr_en          = s_axis.tvalid && s_axis.tready;
  assign frame_len_next = wr_ptr_cur + ONE - wr_ptr_commit;

  always_ff @(posedge clk_i) begin
    if (wr_en && !in_drop)
      mem[wr_ptr_cur[ADDR_WIDTH-1:0]] <= {s_axis.tlast, s_axis.tkeep, s_axis.tdata};
  end

  always_ff @(posedge clk_i) begin
    if (s_rst_i) begin
      wr_ptr_cur    <= '0;
      wr_ptr_commit <= '0;
      wr_state      <= WR_IDLE;
      drop_o        <= 1'b0;
      good_frame_o  <= 1'b0;
    end else begin
      drop_o       <= 1'b0;
      good_frame_o <= 1'b0;
      if (wr_en) begin
        if (!PACKET_MODE) begin
          wr_ptr_cur    <= wr_ptr_cur + ONE;
          wr_ptr_commit <= wr_ptr_cur + ONE;
          good_frame_o  <= s_axis.tlast;
        end else begin
          case (wr_state)
            WR_DROP: begin
              if (s_axis.tlast) begin
                drop_o   <= 1'b1;
                wr_state <= WR_IDLE;
              end
            end
            default: begin
              if (s_axis.tlast) begin
                wr_state <= WR_IDLE;
                if (s_axis.tuser) begin
                  wr_ptr_cur <= wr_ptr_commit;
                  drop_o     <= 1'b1;
                end else begin
                  wr_ptr_cur    <= wr_ptr_cur + ONE;
                  wr_ptr_commit <= wr_ptr_cur + ONE;
                  good_frame_o  <= 1'b1;
                end
              end else if (frame_len_next == DEPTH) begin
                // frame can never fit: roll back now so the write side never deadlocks on full
                wr_ptr_cur <= wr_ptr_commit;
                wr_state   <= WR_DROP;
              end else begin
                wr_ptr_cur <= wr_ptr_cur + ONE;
                wr_state   <= WR_PKT;
              end
            end
          endcase
        end
      end
    end
  end

  assign rd_load = (rd_ptr != wr_ptr_commit) && (!m_axis.tvalid || m_axis.tready);

  always_ff @(posedge clk_i) begin
    if (s_rst_i) begin
      rd_ptr        <= '0;
      m_axis.tvalid <= 1'b0;
      m_axis.tlast  <= 1'b0;
      m_axis.tkeep  <= '0;
      m_axis.tdata  <= '0;
    end else if (rd_load) begin
      {m_axis.tlast, m_axis.tkeep, m_axis.tdata} <= mem[rd_ptr[ADDR_WIDTH-1:0]];
      m_axis.tvalid <= 1'b1;
      rd_ptr        <= rd_ptr + ONE;
    end else if (m_axis.tready) begin
      m_axis.tvalid <= 1'b0;
    end
  end

  assign m_axis.tuser   = 1'b0;
  assign level_o        = wr_ptr_cur - rd_ptr;
  assign almost_full_o  = (DEPTH - level_o) <= AF_TH;
  assign almost_empty_o = level_o <= AE_TH;
endmodule
